// File: rtl/hdlc_field_sequencer.sv
// HDLC field sequencer. It drives a registered byte-select in direct mode, and in
// sequence mode it streams a snapshot of the first seq_len fields over valid/ready.
module hdlc_field_sequencer #(
  parameter int DATA_W = 8,
  parameter int NUM_IN = 32,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     start,
  input  logic [SEL_W:0]           seq_len,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     err_len
);

  localparam logic [0:0]     IDLE     = 1'b0;
  localparam logic [0:0]     SEND     = 1'b1;
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  logic [NUM_IN-1:0][DATA_W-1:0] fields, shadow;
  logic [0:0]       state;
  logic [SEL_W-1:0] idx, idx_nx;
  logic [SEL_W:0]   len_r;
  logic             sel_ok, len_ok, fire, last_nx;

  assign fields  = in_data;
  assign sel_ok  = ({1'b0, sel} < NUM_IN_W);
  assign len_ok  = (seq_len != '0) && (seq_len <= NUM_IN_W);
  assign fire    = out_valid & out_ready;
  assign idx_nx  = idx + SEL_W'(1);
  // The beat that follows is the final one when idx+1 == len_r-1.
  assign last_nx = (({1'b0, idx} + (SEL_W+1)'(2)) == len_r);
  assign busy    = (state == SEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shadow    <= '0;
      idx       <= '0;
      len_r     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      err_len <= 1'b0;
      case (state)
        IDLE: begin
          if (!mode) begin
            out_data <= sel_ok ? fields[sel] : '0;
          end else if (start) begin
            if (len_ok) begin
              shadow    <= fields;
              len_r     <= seq_len;
              idx       <= '0;
              out_data  <= fields[0];
              out_valid <= 1'b1;
              out_last  <= (seq_len == (SEL_W+1)'(1));
              state     <= SEND;
            end else begin
              err_len <= 1'b1;
            end
          end
        end
        default: begin
          // The final beat keeps its data on the bus after it is accepted.
          if (fire) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end else begin
              idx      <= idx_nx;
              out_data <= shadow[idx_nx];
              out_last <= last_nx;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdlc_field_sequencer.sv
// Bench for hdlc_field_sequencer. It compares a snapshot-and-queue reference model
// against a 32-field DUT, and uses a second 22-field DUT for out-of-range select.
module tb_hdlc_field_sequencer;

  logic        clk, rst, mode, start, out_ready;
  logic [4:0]  sel, sel22;
  logic [5:0]  seq_len;
  logic [255:0] in_data;
  logic [7:0]  out_data, out_data22;
  logic        out_valid, out_last, busy, err_len;
  logic        v22, l22, b22, e22;

  logic [7:0]  fld [32];
  int          n_chk = 0;
  int          n_fail = 0;

  hdlc_field_sequencer #(.DATA_W(8), .NUM_IN(32)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .mode(mode), .sel(sel),
    .start(start), .seq_len(seq_len), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .err_len(err_len));

  hdlc_field_sequencer #(.DATA_W(8), .NUM_IN(22)) u_dut22 (
    .clk(clk), .rst(rst), .in_data(in_data[22*8-1:0]), .mode(1'b0), .sel(sel22),
    .start(1'b0), .seq_len(6'd1), .out_data(out_data22), .out_valid(v22),
    .out_ready(1'b0), .out_last(l22), .busy(b22), .err_len(e22));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_in();
    for (int k = 0; k < 32; k++) in_data[k*8 +: 8] = fld[k];
  endtask

  task automatic rand_fields();
    for (int k = 0; k < 32; k++) fld[k] = 8'($urandom);
    drive_in();
  endtask

  // The expected beats are a snapshot of the fields at start, taken in order.
  // Accepted beats are consumed one per ready cycle. Inputs are scrambled
  // while the frame is in flight.
  task automatic run_frame(input int len, input int rdy_pct, input logic [31:0] pat,
                           input int plen, input int abort_at);
    logic [7:0] exp[$];
    int i, j;
    logic rdy;
    exp = {};
    for (int k = 0; k < len; k++) exp.push_back(fld[k]);
    mode = 1'b1; seq_len = 6'(len); start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    i = 0; j = 0;
    while (i < len && j < 4000) begin
      chk("beat_valid", out_valid, 1);
      chk("beat_data", out_data, exp[i]);
      chk("beat_last", out_last, (i == len-1));
      chk("beat_busy", busy, 1);
      chk("beat_err", err_len, 0);
      if (i == abort_at) begin
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        start = 1'b0; mode = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      rdy = (plen > 0 && j < plen) ? pat[j] : ($urandom_range(0, 99) < rdy_pct);
      out_ready = rdy;
      start   = 1'($urandom_range(0, 1));
      mode    = 1'($urandom_range(0, 1));
      seq_len = 6'($urandom_range(0, 40));
      sel     = 5'($urandom);
      rand_fields();
      @(negedge clk);
      if (rdy) i++;
      j++;
    end
    chk("frame_timeout", (j < 4000), 1);
    start = 1'b0; mode = 1'b1; out_ready = 1'b0;
    chk("end_valid", out_valid, 0);
    chk("end_last", out_last, 0);
    chk("end_busy", busy, 0);
    chk("end_data", out_data, exp[len-1]);
  endtask

  task automatic bad_len(input int len);
    mode = 1'b1; seq_len = 6'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", err_len, 1);
    chk("err_busy", busy, 0);
    chk("err_valid", out_valid, 0);
    @(negedge clk);
    chk("err_clear", err_len, 0);
    chk("err_busy2", busy, 0);
  endtask

  initial begin
    int s32 [3];
    int s22 [3];
    logic [7:0] hold;
    rst = 1'b1; mode = 1'b0; sel = '0; sel22 = '0; start = 1'b0;
    seq_len = '0; out_ready = 1'b0; in_data = '0;
    #12;
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_len", err_len, 0);
    @(negedge clk);
    rst = 1'b0;

    // Direct select
    for (int k = 0; k < 32; k++) fld[k] = 8'(8'hA0 + k);
    drive_in();
    s32 = '{0, 5, 31};
    s22 = '{25, 21, 3};
    for (int t = 0; t < 3; t++) begin
      sel = 5'(s32[t]); sel22 = 5'(s22[t]);
      @(negedge clk);
      chk("direct_data", out_data, 8'hA0 + s32[t]);
      chk("direct_valid", out_valid, 0);
      chk("direct22_data", out_data22, (s22[t] < 22) ? 8'hA0 + s22[t] : 0);
    end

    // Sequence mode without start holds the last output.
    mode = 1'b1; sel = 5'd2;
    @(negedge clk);
    chk("idle_hold", out_data, 8'hBF);

    // Full-rate stream
    fld[0] = 8'h11; fld[1] = 8'h22; fld[2] = 8'h33; fld[3] = 8'h44;
    drive_in();
    run_frame(4, 100, 0, 0, -1);

    // Backpressure pattern 0,0,1,0,1,1
    rand_fields();
    run_frame(3, 0, 32'b110100, 6, -1);

    // Boundary lengths, issued back-to-back
    rand_fields();
    run_frame(1, 100, 0, 0, -1);
    run_frame(32, 100, 0, 0, -1);
    run_frame(32, 60, 0, 0, -1);
    bad_len(0);
    bad_len(33);

    // Random frames with random backpressure and ignored start requests
    for (int f = 0; f < 10; f++) begin
      run_frame(int'($urandom_range(1, 32)), int'($urandom_range(30, 100)), 0, 0, -1);
    end

    // Asynchronous reset at beat 2 of 5, then a fresh frame
    rand_fields();
    run_frame(5, 100, 0, 0, 2);
    chk("post_rst_busy", busy, 0);
    run_frame(5, 70, 0, 0, -1);

    hold = out_data;
    @(negedge clk);
    @(negedge clk);
    chk("final_hold", out_data, hold);
    chk("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
